// File: rtl/mem_arbiter.sv
// Shares the single cacheline memory port between icache and dcache.
// D has priority; I is forced through after STARVE_MAX consecutive D grants.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int LINE_W     = 256,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] LINE_MASK  = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              d_req, grant_i, grant_d;

   always_comb begin
      d_req        = d_read | d_write;
      grant_d      = 1'b0;
      grant_i      = 1'b0;
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wr_d         = wr_q;
      case (state_q)
         IDLE: begin
            grant_d = d_req && !(i_read && starve_cnt_q == STARVE_LIM);
            grant_i = i_read && !grant_d;
            if (grant_d) begin
               state_d = D_ACC;
               addr_d  = d_addr & LINE_MASK;
               wdata_d = d_wdata;
               wr_d    = d_write;   // a simultaneous read+write resolves as write
            end else if (grant_i) begin
               state_d = I_ACC;
               addr_d  = i_addr & LINE_MASK;
               wr_d    = 1'b0;
            end
            // Counter only tracks D grants that actually made a waiting I wait longer
            if (!i_read || grant_i)
               starve_cnt_d = '0;
            else if (grant_d && starve_cnt_q != STARVE_LIM)
               starve_cnt_d = starve_cnt_q + 1'b1;
         end
         I_ACC, D_ACC: if (pmem_resp) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wr_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wr_q         <= wr_d;
      end
   end

   // Strobes decode from state so an async reset drops them immediately
   assign pmem_read  = (state_q == I_ACC) || (state_q == D_ACC && !wr_q);
   assign pmem_write = (state_q == D_ACC) && wr_q;
   assign pmem_addr  = addr_q;
   assign pmem_wdata = wdata_q;
   assign i_resp     = (state_q == I_ACC) && pmem_resp;
   assign d_resp     = (state_q == D_ACC) && pmem_resp;
   assign i_rdata    = pmem_rdata;
   assign d_rdata    = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level ownership model of the memory port.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_read, d_read, d_write, pmem_resp;
   logic [AW-1:0] i_addr, d_addr;
   logic [LW-1:0] d_wdata, pmem_rdata;
   logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
   logic [AW-1:0] pmem_addr;
   logic          i_resp, d_resp, pmem_read, pmem_write;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Model: who owns the memory port (0 none, 1 icache, 2 dcache), plus
   // how many D grants in a row have overtaken a waiting I request.
   int            owner = 0;
   int            streak = 0;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata;
   bit            m_wr;
   string         resp_str;
   bit            i_done, d_done;

   always @(posedge clk)
      if (rst_n) assert (!(d_read && d_write)) else $error("d_read and d_write both high");

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] str2v(input string s);
      logic [LW-1:0] v = '0;
      for (int k = 0; k < s.len(); k++) v = {v[LW-9:0], s[k]};
      return v;
   endfunction

   // One clock cycle: inputs already applied; compare at negedge, advance model.
   task automatic step();
      int n_owner;
      int n_streak;
      bit dq;
      @(negedge clk);
      check("pmem_read", pmem_read, (owner == 1) || (owner == 2 && !m_wr));
      check("pmem_write", pmem_write, owner == 2 && m_wr);
      check("i_resp", i_resp, owner == 1 && pmem_resp);
      check("d_resp", d_resp, owner == 2 && pmem_resp);
      if (owner != 0) check("pmem_addr", pmem_addr, m_addr);
      if (owner == 2 && m_wr) check("pmem_wdata", pmem_wdata, m_wdata);
      if (owner == 1 && pmem_resp) check("i_rdata", i_rdata, pmem_rdata);
      if (owner == 2 && pmem_resp && !m_wr) check("d_rdata", d_rdata, pmem_rdata);
      if (i_resp) resp_str = {resp_str, "I"};
      if (d_resp) resp_str = {resp_str, "D"};
      i_done = i_resp;
      d_done = d_resp;
      n_owner  = owner;
      n_streak = streak;
      if (owner != 0) begin
         if (pmem_resp) n_owner = 0;
      end else begin
         dq = d_read || d_write;
         if (dq && !(i_read && streak == SM)) begin
            n_owner = 2;
            m_wr    = d_write;
            m_addr  = d_addr & ~32'h1F;
            m_wdata = d_wdata;
         end else if (i_read) begin
            n_owner = 1;
            m_wr    = 1'b0;
            m_addr  = i_addr & ~32'h1F;
         end
         if (!i_read || n_owner == 1) n_streak = 0;
         else if (n_owner == 2) n_streak = (streak < SM) ? streak + 1 : SM;
      end
      @(posedge clk);
      #1;
      owner  = n_owner;
      streak = n_streak;
   endtask

   task automatic new_d_req();
      bit w;
      w       = $urandom_range(0, 1);
      d_read  = !w;
      d_write = w;
      d_addr  = $urandom;
      for (int k = 0; k < 8; k++) d_wdata[k*32 +: 32] = $urandom;
   endtask

   initial begin
      i_read = 0; d_read = 0; d_write = 0; pmem_resp = 1;
      i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
      i_done = 0; d_done = 0; resp_str = "";

      // Reset values, with pmem_resp high to show it is ignored
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pmem_read", pmem_read, 0);
      check("rst_pmem_write", pmem_write, 0);
      check("rst_pmem_addr", pmem_addr, 0);
      check("rst_pmem_wdata", pmem_wdata, 0);
      check("rst_i_resp", i_resp, 0);
      check("rst_d_resp", d_resp, 0);
      @(posedge clk);
      #1 rst_n = 1; pmem_resp = 0;

      // Lone I miss, memory answers in cycle 4
      resp_str = "";
      i_read = 1; i_addr = 32'h0000_1234;
      step();
      for (int c = 1; c <= 4; c++) begin
         pmem_resp  = (c == 4);
         pmem_rdata = {32{8'hA5}};
         #1;
         if (c == 1) check("lone_i_addr", pmem_addr, 32'h0000_1220);
         step();
      end
      i_read = 0; pmem_resp = 0;
      step(); step();
      check("lone_i_resps", str2v(resp_str), str2v("I"));

      // Lone D writeback
      resp_str = "";
      d_write = 1; d_addr = 32'h8000_0040;
      d_wdata = {2{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};
      step();
      pmem_resp = 1;
      #1;
      check("lone_d_addr", pmem_addr, 32'h8000_0040);
      check("lone_d_wdata", pmem_wdata, {2{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}});
      step();
      d_write = 0; pmem_resp = 0;
      step(); step();
      check("lone_d_resps", str2v(resp_str), str2v("D"));

      // Simultaneous I and D: D first, I on the memory port two cycles after d_resp
      resp_str = "";
      i_read = 1; i_addr = 32'h2000_0104;
      d_read = 1; d_addr = 32'h3000_0208;
      step();
      #1 check("both_d_first", pmem_addr, 32'h3000_0200);
      step();
      pmem_resp = 1;
      step();
      d_read = 0; pmem_resp = 0;
      #1 check("both_bubble", pmem_read, 0);
      step();
      pmem_resp = 1;
      #1 check("both_i_addr", pmem_addr, 32'h2000_0100);
      step();
      i_read = 0; pmem_resp = 0;
      step();
      check("both_order", str2v(resp_str), str2v("DI"));

      // Starvation: I and D both keep requesting, memory always ready
      resp_str = "";
      i_read = 1; i_addr = 32'h0000_4000;
      d_read = 1; d_addr = 32'h0000_8000;
      pmem_resp = 1;
      begin
         int ni = 0;
         for (int c = 0; c < 60 && ni < 2; c++) begin
            step();
            if (i_done) ni++;
         end
      end
      i_read = 0; d_read = 0; pmem_resp = 0;
      step(); step();
      check("starve_order", str2v(resp_str), str2v("DDDDIDDDDI"));

      // Async reset between edges while D_ACC owns the port
      d_read = 1; d_addr = 32'h4000_0080; pmem_resp = 0;
      step();
      pmem_resp = 1;
      #2 rst_n = 0;
      #1;
      check("arst_pmem_read", pmem_read, 0);
      check("arst_pmem_write", pmem_write, 0);
      check("arst_pmem_addr", pmem_addr, 0);
      check("arst_d_resp", d_resp, 0);
      owner = 0; streak = 0; d_read = 0;
      @(posedge clk);
      #1 rst_n = 1;
      resp_str = "";
      repeat (3) step();
      check("arst_no_resp", str2v(resp_str), '0);

      // Spurious memory responses while idle
      resp_str = "";
      for (int c = 0; c < 4; c++) begin
         pmem_resp = 1;
         pmem_rdata = {8{$urandom}};
         step();
      end
      pmem_resp = 0;
      check("spurious_no_resp", str2v(resp_str), '0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         if (i_done) begin
            i_read = ($urandom_range(0, 2) == 0);
            i_addr = $urandom;
         end else if (!i_read && $urandom_range(0, 3) == 0) begin
            i_read = 1;
            i_addr = $urandom;
         end
         if (d_done) begin
            if ($urandom_range(0, 2) == 0) new_d_req();
            else begin d_read = 0; d_write = 0; end
         end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
            new_d_req();
         end
         pmem_resp = ($urandom_range(0, 2) == 0);
         for (int k = 0; k < 8; k++) pmem_rdata[k*32 +: 32] = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
